// File: rtl/iobus_timer_pkg.sv
// Shared register offsets, CTRL bit positions and FSM encoding for iobus_timer.
package iobus_timer_pkg;

  // Word offsets within the timer window (byte addresses, [1:0] always 0)
  localparam logic [4:0] CTRL_OFF   = 5'h00;
  localparam logic [4:0] PRESC_OFF  = 5'h04;
  localparam logic [4:0] RELOAD_OFF = 5'h08;
  localparam logic [4:0] COUNT_OFF  = 5'h0C;
  localparam logic [4:0] STATUS_OFF = 5'h10;

  // CTRL register bit positions
  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_AUTO = 1;
  localparam int unsigned CTRL_IE   = 2;

  // STATUS register bit positions
  localparam int unsigned STATUS_PEND = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_e;

  // Word-aligned offset inside the 32-byte decode block; byte lanes are ignored.
  function automatic logic [4:0] word_off(input logic [31:0] addr);
    return {addr[4:2], 2'b00};
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running prescaler: counts while running, ticks and wraps when the
// count matches the compare value.
module timer_prescaler #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_run,
  input  logic                  i_clear,
  input  logic [PRESCALE_W-1:0] i_presc,
  output logic                  o_tick
);

  logic [PRESCALE_W-1:0] r_cnt;
  logic                  w_match;

  assign w_match = (r_cnt == i_presc);
  // The tick is still produced in a cycle that also clears, so an expiry
  // coinciding with a disable is not lost.
  assign o_tick  = i_run && w_match;

  // Prescale counter: cleared on reset or request, wraps on match while running
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_run) begin
      if (w_match) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/iobus_timer.sv
// Memory-mapped countdown timer on the IOBUS with prescaler, optional
// auto-reload and a level interrupt.
module iobus_timer
  import iobus_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        INTR
);

  logic [2:0]            r_ctrl;
  logic [PRESCALE_W-1:0] r_presc;
  logic [31:0]           r_reload;
  logic [31:0]           r_count;
  logic                  r_pend;
  logic                  r_intr;
  logic [31:0]           r_rdata;
  timer_state_e          r_state;

  logic [4:0]            w_off;
  logic                  w_hit;
  logic                  w_wr_ctrl;
  logic                  w_wr_presc;
  logic                  w_wr_reload;
  logic                  w_wr_count;
  logic                  w_wr_status;
  logic                  w_tick;
  logic                  w_expire;
  logic                  w_presc_clr;
  logic [2:0]            w_ctrl_nxt;
  timer_state_e          w_state_nxt;
  logic [31:0]           w_rdata;
  logic                  w_unused;

  // Byte-lane bits carry no meaning for word registers
  assign w_unused = ^IOBUS_ADDR[1:0];

  assign w_off = word_off(IOBUS_ADDR);
  assign w_hit = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]) && (w_off <= STATUS_OFF);

  assign w_wr_ctrl   = IOBUS_WR && w_hit && (w_off == CTRL_OFF);
  assign w_wr_presc  = IOBUS_WR && w_hit && (w_off == PRESC_OFF);
  assign w_wr_reload = IOBUS_WR && w_hit && (w_off == RELOAD_OFF);
  assign w_wr_count  = IOBUS_WR && w_hit && (w_off == COUNT_OFF);
  assign w_wr_status = IOBUS_WR && w_hit && (w_off == STATUS_OFF);

  timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_run   (r_state == RUN),
    .i_clear (w_presc_clr),
    .i_presc (r_presc),
    .o_tick  (w_tick)
  );

  // Ticks only occur in RUN, so this is the RUN-state expiry condition
  assign w_expire = w_tick && (r_count == '0);

  // FSM next state, prescaler clear and CTRL update; a CTRL write takes
  // priority over the EN auto-clear of a one-shot expiry
  always_comb begin
    w_state_nxt = r_state;
    w_presc_clr = 1'b0;
    w_ctrl_nxt  = r_ctrl;
    if (w_wr_ctrl) begin
      w_ctrl_nxt = IOBUS_OUT[2:0];
    end
    case (r_state)
      IDLE, DONE: begin
        if (w_wr_ctrl && IOBUS_OUT[CTRL_EN]) begin
          w_state_nxt = RUN;
          w_presc_clr = 1'b1;
        end
      end
      RUN: begin
        if (w_wr_ctrl) begin
          if (!IOBUS_OUT[CTRL_EN]) begin
            w_state_nxt = IDLE;
            w_presc_clr = 1'b1;
          end
        end else if (w_expire && !r_ctrl[CTRL_AUTO]) begin
          w_state_nxt         = DONE;
          w_ctrl_nxt[CTRL_EN] = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM and control register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ctrl  <= w_ctrl_nxt;
    end
  end

  // Prescale compare and reload value registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_presc  <= '0;
      r_reload <= '0;
    end else begin
      if (w_wr_presc) begin
        r_presc <= IOBUS_OUT[PRESCALE_W-1:0];
      end
      if (w_wr_reload) begin
        r_reload <= IOBUS_OUT;
      end
    end
  end

  // Countdown register: a bus write beats the tick in the same cycle
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_count <= '0;
    end else if (w_wr_count) begin
      r_count <= IOBUS_OUT;
    end else if (w_expire) begin
      if (r_ctrl[CTRL_AUTO]) begin
        r_count <= r_reload;
      end
    end else if (w_tick) begin
      r_count <= r_count - 32'd1;
    end
  end

  // Pending flag: expiry set has priority over write-one-to-clear
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pend <= 1'b0;
    end else if (w_expire) begin
      r_pend <= 1'b1;
    end else if (w_wr_status && IOBUS_OUT[STATUS_PEND]) begin
      r_pend <= 1'b0;
    end
  end

  // Registered interrupt level
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_intr <= 1'b0;
    end else begin
      r_intr <= r_pend && r_ctrl[CTRL_IE];
    end
  end

  // Read mux over pre-write register state
  always_comb begin
    w_rdata = '0;
    case (w_off)
      CTRL_OFF:   w_rdata = {29'd0, r_ctrl};
      PRESC_OFF:  w_rdata = 32'(r_presc);
      RELOAD_OFF: w_rdata = r_reload;
      COUNT_OFF:  w_rdata = r_count;
      STATUS_OFF: w_rdata = {31'd0, r_pend};
      default:    w_rdata = '0;
    endcase
  end

  // Registered read data, one cycle after the address
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rdata <= '0;
    end else if (w_hit) begin
      r_rdata <= w_rdata;
    end else begin
      r_rdata <= '0;
    end
  end

  assign IOBUS_IN = r_rdata;
  assign INTR     = r_intr;

endmodule

// File: tb/tb_iobus_timer.sv
// Scoreboard bench for iobus_timer: stimulus pushes hand-computed expected
// read data / interrupt level, a monitor pops and compares one cycle later.
module tb_iobus_timer;

  localparam logic [31:0] B = 32'h1100_0100;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] IOBUS_ADDR = '0;
  logic [31:0] IOBUS_OUT = '0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] IOBUS_IN;
  logic        INTR;

  typedef struct {
    bit          crd;
    logic [31:0] rd;
    bit          ci;
    bit          intr;
    string       nm;
  } exp_t;

  exp_t sb[$];
  bit   rd_req  = 1'b0;
  bit   mon_v   = 1'b0;
  bit   rst_req = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  iobus_timer #(
    .BASE_ADDR  (32'h1100_0100),
    .PRESCALE_W (16)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .IOBUS_IN   (IOBUS_IN),
    .INTR       (INTR)
  );

  always #5 CLK = ~CLK;

  // Response for the bus cycle sampled at a posedge is visible at the next negedge
  always @(posedge CLK) mon_v <= rd_req;

  always @(negedge CLK) begin
    if (mon_v) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: response presented with no expectation queued");
      end else begin
        e = sb.pop_front();
        if (e.crd) begin
          checks++;
          if (IOBUS_IN !== e.rd) begin
            errors++;
            $display("FAIL %s: IOBUS_IN got %08h expected %08h", e.nm, IOBUS_IN, e.rd);
          end
        end
        if (e.ci) begin
          checks++;
          if (INTR !== e.intr) begin
            errors++;
            $display("FAIL %s_intr: INTR got %b expected %b", e.nm, INTR, e.intr);
          end
        end
      end
    end
  end

  // ei: -1 no INTR check, 0/1 expected INTR level
  task automatic bus(input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input bit crd, input logic [31:0] erd, input int ei, input string nm);
    exp_t e;
    @(negedge CLK);
    RESET      = rst_req;
    IOBUS_WR   = wr;
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    rd_req     = crd || (ei >= 0);
    if (rd_req) begin
      e.crd  = crd;
      e.rd   = erd;
      e.ci   = (ei >= 0);
      e.intr = (ei == 1);
      e.nm   = nm;
      sb.push_back(e);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 1'b0, '0, -1, "");
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] erd, input int ei, input string nm);
    bus(1'b0, a, '0, 1'b1, erd, ei, nm);
  endtask

  task automatic idle();
    bus(1'b0, '0, '0, 1'b0, '0, -1, "");
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1; IOBUS_WR = 1'b0; IOBUS_ADDR = '0; IOBUS_OUT = '0; rd_req = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state of every register and the interrupt
    do_reset();
    rd(B + 32'h00, 32'h0, 0, "rst_ctrl");
    rd(B + 32'h04, 32'h0, 0, "rst_presc");
    rd(B + 32'h08, 32'h0, 0, "rst_reload");
    rd(B + 32'h0C, 32'h0, 0, "rst_count");
    rd(B + 32'h10, 32'h0, 0, "rst_status");

    // One-shot, PRESC = 0
    do_reset();
    wr(B + 32'h0C, 32'd3);
    wr(B + 32'h00, 32'h5);
    rd(B + 32'h00, 32'h5, 0, "os_ctrl_run");
    rd(B + 32'h0C, 32'd2, 0, "os_cnt2");
    rd(B + 32'h0C, 32'd1, 0, "os_cnt1");
    rd(B + 32'h0C, 32'd0, 0, "os_cnt0");
    rd(B + 32'h10, 32'h1, 1, "os_pend");
    rd(B + 32'h00, 32'h4, 1, "os_ctrl_done");
    rd(B + 32'h0C, 32'd0, 1, "os_cnt_hold");
    rd(B + 32'h0C, 32'd0, 1, "os_cnt_hold2");
    bus(1'b1, B + 32'h00, 32'h0, 1'b1, 32'h4, 1, "os_ie_clear");
    rd(B + 32'h10, 32'h1, 0, "os_pend_kept");
    bus(1'b1, B + 32'h10, 32'h1, 1'b1, 32'h1, 0, "os_w1c");
    rd(B + 32'h10, 32'h0, 0, "os_pend_clr");

    // Auto-reload, PRESC = 1 (tick every 2 cycles)
    do_reset();
    wr(B + 32'h04, 32'd1);
    wr(B + 32'h08, 32'd2);
    wr(B + 32'h0C, 32'd2);
    wr(B + 32'h00, 32'h7);
    rd(B + 32'h0C, 32'd2, 0, "au_c2a");
    rd(B + 32'h0C, 32'd2, 0, "au_c2b");
    rd(B + 32'h0C, 32'd1, 0, "au_c1a");
    rd(B + 32'h0C, 32'd1, 0, "au_c1b");
    rd(B + 32'h0C, 32'd0, 0, "au_c0a");
    rd(B + 32'h0C, 32'd0, 0, "au_c0b");
    rd(B + 32'h0C, 32'd2, 1, "au_reload");
    rd(B + 32'h10, 32'h1, 1, "au_pend");
    bus(1'b1, B + 32'h10, 32'h1, 1'b1, 32'h1, 1, "au_w1c");
    rd(B + 32'h10, 32'h0, 0, "au_pend_clr");
    rd(B + 32'h0C, 32'd0, 0, "au_c0c");
    bus(1'b1, B + 32'h10, 32'h1, 1'b1, 32'h0, 0, "au_w1c_at_expiry");
    rd(B + 32'h10, 32'h1, 1, "au_set_wins");
    bus(1'b1, B + 32'h08, 32'd4, 1'b1, 32'd2, 1, "au_reload_wr");
    rd(B + 32'h0C, 32'd1, -1, "au_reload_deferred");
    idle();
    idle();
    rd(B + 32'h0C, 32'd0, -1, "au_c0d");
    rd(B + 32'h0C, 32'd4, -1, "au_new_reload");
    bus(1'b1, B + 32'h0C, 32'd10, 1'b1, 32'd4, -1, "au_collide_old");
    rd(B + 32'h0C, 32'd10, -1, "au_collide");
    rd(B + 32'h0C, 32'd10, -1, "au_collide_b");
    rd(B + 32'h0C, 32'd9, -1, "au_after_collide");

    // Address decode
    do_reset();
    wr(B + 32'h20, 32'hFFFF_FFFF);
    rd(B + 32'h00, 32'h0, 0, "dec_miss_ctrl");
    rd(B + 32'h04, 32'h0, -1, "dec_miss_presc");
    rd(B + 32'h08, 32'h0, -1, "dec_miss_reload");
    rd(B + 32'h0C, 32'h0, -1, "dec_miss_count");
    wr(B + 32'h08, 32'hA5A5_0001);
    rd(B + 32'h14, 32'h0, -1, "dec_rd_miss");
    rd(B + 32'h08, 32'hA5A5_0001, -1, "dec_reload");
    wr(B + 32'h0E, 32'h1234);
    rd(B + 32'h0C, 32'h1234, -1, "dec_unaligned_wr");
    bus(1'b1, B + 32'h0D, 32'h55, 1'b1, 32'h1234, -1, "dec_rd_before_wr");
    rd(B + 32'h0C, 32'h55, -1, "dec_after_wr");
    wr(B + 32'h04, 32'hFFFF_FFFF);
    rd(B + 32'h04, 32'h0000_FFFF, -1, "dec_presc_width");
    wr(B + 32'h00, 32'hFFFF_FFF8);
    rd(B + 32'h00, 32'h0, -1, "dec_ctrl_bits");
    wr(32'h1200_010C, 32'd7);
    rd(B + 32'h0C, 32'h55, -1, "dec_upper_miss");

    // Reset asserted mid-count
    do_reset();
    wr(B + 32'h0C, 32'd5);
    wr(B + 32'h00, 32'h7);
    rd(B + 32'h0C, 32'd5, -1, "mr_c5");
    rd(B + 32'h0C, 32'd4, -1, "mr_c4");
    rst_req = 1'b1;
    rd(B + 32'h0C, 32'd0, 0, "mr_rdata_reset");
    rst_req = 1'b0;
    rd(B + 32'h0C, 32'd0, 0, "mr_count");
    rd(B + 32'h00, 32'h0, 0, "mr_ctrl");
    rd(B + 32'h0C, 32'd0, 0, "mr_no_decrement");
    rd(B + 32'h10, 32'h0, 0, "mr_status");
    rd(B + 32'h0C, 32'd0, 0, "mr_count_idle");

    idle();
    idle();
    @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
